shift_seq: RTL and testbench
============================

// Module: shift_seq
//
// PURPOSE
//   Multi-cycle shift unit for the datapath. It applies the single-bit shift
//   ops (NO_SHIFT/LS/RS_MSB_0/RS_MSB_CP) AMOUNT times, one bit per clock, under
//   a start/done handshake. The controller FSM starts it and waits for done,
//   then latches sout into the writeback path. It replaces the combinational
//   1-bit shifter wherever an N-bit shift is needed.
//
// PARAMETERS
//   WIDTH   16  data width of in/sout
//   AMT_W   4   width of shift amount (0..2^AMT_W-1 bit positions)
//
// PORTS
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-high; clears all state
//   start   in   1      request; sampled only in IDLE
//   in      in   WIDTH  operand; captured on the accepted start edge
//   shift   in   2      op: 00 NO_SHIFT, 01 LS, 10 RS_MSB_0, 11 RS_MSB_CP
//   amount  in   AMT_W  number of 1-bit steps; captured with in
//   busy    out  1      1 in SHIFT and DONE states
//   done    out  1      one-cycle pulse, result valid on sout
//   sout    out  WIDTH  registered result; holds until next result loads
//
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, sout=0, internal work/count regs=0.
//   Clock and reset are the only timing references. All outputs are registered.
//   States:
//     IDLE  -> start=1 at edge E0: work<=in, op<=shift, cnt<=amount.
//              If amount==0 or shift==NO_SHIFT, go to DONE with sout<=in.
//              Otherwise go to SHIFT.
//     SHIFT -> each edge: work<=step(work), cnt<=cnt-1.
//              When cnt==1: sout<=step(work) and go to DONE.
//     DONE  -> done=1 for exactly this cycle; next edge goes to IDLE.
//   step(): LS     {w[WIDTH-2:0],1'b0}
//           RS_MSB_0  {1'b0,w[WIDTH-1:1]}
//           RS_MSB_CP {w[WIDTH-1],w[WIDTH-1:1]}
//           LS inserts 0 at the lsb; RS_MSB_CP replicates the original msb
//           on every step (arithmetic shift).
//   Latency: done is high in the cycle after edge E0+A, with A = amount
//     (A treated as 0 for NO_SHIFT). Minimum: done in the cycle right after E0.
//   Throughput: a new start is accepted in IDLE. Back-to-back start is
//     accepted the cycle after done.
//   start while busy (SHIFT or DONE) is ignored; it is neither queued nor
//     allowed to corrupt work/op/cnt.
//   in/shift/amount may change after E0 without effect.
//   sout changes only on entry to DONE; otherwise it holds its previous value.
//   Maximum amount (2^AMT_W-1) is valid. LS or RS_MSB_0 by 15 on 16 bits leaves
//     one surviving bit. There is no wrap or rotate.
//   Reset mid-operation (any state): returns to IDLE immediately, busy=0,
//     done=0, sout=0. The operation in flight is discarded and no done pulse
//     is issued.
//
// TESTING
//   1. in=16'h8421, LS, amount=4, start 1 cycle -> busy for 5 cycles;
//      done pulse after E0+4; sout=16'h4210.
//   2. in=16'h8421, RS_MSB_CP, amount=3 -> sout=16'hF084;
//      then in=16'h4210, RS_MSB_CP, amount=1 -> sout=16'h2108.
//   3. in=16'h8000, RS_MSB_0, amount=15 -> sout=16'h0001, done after E0+15;
//      same input with RS_MSB_CP -> sout=16'hFFFF.
//   4. in=16'h1234, NO_SHIFT, amount=9; then LS, amount=0 -> each gives done
//      the cycle after E0 and sout=16'h1234.
//   5. Start LS amount=8 on 16'h00FF, pulse start again mid-SHIFT with
//      in=16'hFFFF -> second start ignored, sout=16'hFF00, exactly one done.
//   6. Start RS_MSB_0 amount=10, assert reset async at E0+3 ->
//      busy=0/done=0/sout=0 without waiting for a clock edge; no done pulse;
//      a following start with in=16'h0F00, amount=8 gives sout=16'h000F.
//   The bench checks with !==, flags any X/Z on outputs, and prints PASS/FAIL.

Source files
------------

// File: rtl/shift_seq.sv
// Multi-cycle shifter: applies a 1-bit shift op `amount` times, one step per
// clock, under a start/done handshake. Result is held on sout until the next
// operation completes.
module shift_seq #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       shift,
   input  logic [AMT_W-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sout
);

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_LS    = 2'b01;
   localparam logic [1:0] OP_RS_0  = 2'b10;
   localparam logic [1:0] OP_RS_CP = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t             state_reg;
   logic [WIDTH-1:0]   work_reg;
   logic [1:0]         op_reg;
   logic [AMT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   sout_reg;
   logic               busy_reg;
   logic               done_reg;

   // One 1-bit step of the selected op; arithmetic right keeps the msb.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w,
                                             input logic [1:0] op);
      logic [WIDTH-1:0] r;
      case (op)
         OP_LS:    r = {w[WIDTH-2:0], 1'b0};
         OP_RS_0:  r = {1'b0, w[WIDTH-1:1]};
         OP_RS_CP: r = {w[WIDTH-1], w[WIDTH-1:1]};
         default:  r = w;
      endcase
      return r;
   endfunction

   logic [WIDTH-1:0] work_step;
   assign work_step = step(work_reg, op_reg);

   // Control FSM with registered busy/done/sout; start is only looked at in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         work_reg  <= '0;
         op_reg    <= OP_NONE;
         cnt_reg   <= '0;
         sout_reg  <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  work_reg <= in;
                  op_reg   <= shift;
                  cnt_reg  <= amount;
                  busy_reg <= 1'b1;
                  // Zero-step operations complete immediately with the operand.
                  if (amount == '0 || shift == OP_NONE) begin
                     sout_reg  <= in;
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     state_reg <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work_reg <= work_step;
               cnt_reg  <= cnt_reg - AMT_W'(1);
               if (cnt_reg == AMT_W'(1)) begin
                  sout_reg  <= work_step;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign sout = sout_reg;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: directed cases plus random operations; expected results
// and done timing are pushed to a scoreboard queue and checked by a monitor.
module tb_shift_seq;

   localparam int WIDTH = 16;
   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [1:0]       shift = 2'b00;
   logic [AMT_W-1:0] amount = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sout;

   shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .in(din), .shift(shift),
      .amount(amount), .busy(busy), .done(done), .sout(sout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] val;
      int               cyc;
   } exp_t;

   exp_t             sb_q[$];
   int               checks = 0;
   int               failures = 0;
   int               cyc = 0;
   int               done_seen = 0;
   int               done_exp = 0;
   logic [WIDTH-1:0] last_sout = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: whole shift in one arithmetic step.
   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] v,
                                              input logic [1:0] op,
                                              input int a);
      logic [WIDTH-1:0] r;
      case (op)
         2'b01:   r = v << a;
         2'b10:   r = v >> a;
         2'b11:   r = WIDTH'($signed(v) >>> a);
         default: r = v;
      endcase
      return r;
   endfunction

   // Monitor: pops an expectation on every done pulse; sout must hold otherwise.
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if ($isunknown({busy, done, sout})) begin
            failures++;
            $display("FAIL xz_outputs: got busy=%b done=%b sout=%h expected known values", busy, done, sout);
         end
         if (done === 1'b1) begin
            done_seen++;
            if (sb_q.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("sout_result", sout, e.val);
               chk("done_cycle", cyc, e.cyc);
               last_sout = e.val;
            end
         end else begin
            chk("sout_hold", sout, last_sout);
         end
      end
   end

   // Issue one operation from a negedge in IDLE; optionally pulse a stray start
   // mid-operation. Returns at the negedge where busy has fallen.
   task automatic run_op(input logic [WIDTH-1:0] v, input logic [1:0] op,
                         input int a, input bit inject);
      exp_t e;
      int   a_eff;
      int   n;
      a_eff  = (op == 2'b00) ? 0 : a;
      start  = 1'b1;
      din    = v;
      shift  = op;
      amount = AMT_W'(a);
      e.val  = model(v, op, a_eff);
      e.cyc  = cyc + 1 + a_eff;
      sb_q.push_back(e);
      done_exp++;
      @(negedge clk);
      start  = 1'b0;
      din    = WIDTH'($urandom);
      shift  = 2'($urandom);
      amount = AMT_W'($urandom);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         if (inject && n == 3) begin
            start = 1'b1;
            din   = 16'hFFFF;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_cycles", n, a_eff + 1);
      $display("op in=%h shift=%0d amount=%0d exp=%h busy_cycles=%0d", v, op, a, e.val, n);
   endtask

   initial begin
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_sout", sout, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run_op(16'h8421, 2'b01, 4, 0);
      run_op(16'h8421, 2'b11, 3, 0);
      run_op(16'h4210, 2'b11, 1, 0);
      run_op(16'h8000, 2'b10, 15, 0);
      run_op(16'h8000, 2'b11, 15, 0);
      run_op(16'h1234, 2'b00, 9, 0);
      run_op(16'h1234, 2'b01, 0, 0);
      run_op(16'h00FF, 2'b01, 8, 1);
      run_op(16'hFFFF, 2'b01, 15, 0);

      // Async reset in the middle of a shift: no done, outputs clear at once.
      start  = 1'b1;
      din    = 16'hABCD;
      shift  = 2'b10;
      amount = AMT_W'(10);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_sout", sout, 0);
      $display("async reset mid-shift busy=%b done=%b sout=%h", busy, done, sout);
      last_sout = '0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_op(16'h0F00, 2'b10, 8, 0);

      for (int i = 0; i < 40; i++) begin
         run_op(WIDTH'($urandom), 2'($urandom), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 0);
      chk("done_count", done_seen, done_exp);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
